// File: rtl/int2fp32_rr_sched.sv
// int2fp32_rr_sched: round-robin front end sharing one unsigned INT->FP32
// converter among NUM_REQ requesters. Each accepted word is captured, then
// converted, then held on a valid/ready output until the consumer takes it.
// Conversion truncates: low bits that do not fit the 23-bit mantissa are
// dropped.
module int2fp32_rr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_fp32,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          busy
);

  localparam int MSB_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic [ID_WIDTH-1:0]   cap_id_q, cap_id_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_fp32_q, out_fp32_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  grant_vld;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   grant_nxt;
  logic [ID_WIDTH:0]     grant_sum;
  logic [ID_WIDTH:0]     nxt_sum;

  logic [MSB_W-1:0]      msb;
  logic [7:0]            cvt_exp;
  logic [DATA_WIDTH-1:0] cvt_shift;
  logic [31:0]           cvt_fp32;

  // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit
  // of the rotated vector is the offset of the winner from the pointer.
  always_comb begin
    req_dbl   = {req_valid, req_valid};
    req_rot   = NUM_REQ'(req_dbl >> rr_ptr_q);
    grant_vld = 1'b0;
    grant_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && req_rot[k]) begin
        grant_vld = 1'b1;
        grant_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      end
    end
    if (grant_sum >= (ID_WIDTH+1)'(NUM_REQ))
      grant_sum = grant_sum - (ID_WIDTH+1)'(NUM_REQ);
    grant_idx = grant_sum[ID_WIDTH-1:0];
    nxt_sum   = {1'b0, grant_idx} + (ID_WIDTH+1)'(1);
    if (nxt_sum >= (ID_WIDTH+1)'(NUM_REQ))
      nxt_sum = '0;
    grant_nxt = nxt_sum[ID_WIDTH-1:0];
  end

  // Accept pulse only to the winner, only in IDLE, never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld && !rst)
      req_ready[grant_idx] = 1'b1;
  end

  // Shared converter: normalise on the leading one and truncate to 23 bits.
  always_comb begin
    msb = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (cap_data_q[i]) msb = MSB_W'(i);
    cvt_exp = 8'd127 + 8'(msb);
    if (msb <= MSB_W'(23))
      cvt_shift = cap_data_q << (MSB_W'(23) - msb);
    else
      cvt_shift = cap_data_q >> (msb - MSB_W'(23));
    if (cap_data_q == '0)
      cvt_fp32 = 32'h0000_0000;
    else
      cvt_fp32 = {1'b0, cvt_exp, cvt_shift[22:0]};
  end

  // Next-state logic for the IDLE -> CONV -> HOLD -> IDLE sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cap_data_d  = cap_data_q;
    cap_id_d    = cap_id_q;
    out_valid_d = out_valid_q;
    out_fp32_d  = out_fp32_q;
    out_id_d    = out_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          cap_data_d = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          cap_id_d   = grant_idx;
          rr_ptr_d   = grant_nxt;
          state_d    = CONV;
        end
      end
      CONV: begin
        out_fp32_d  = cvt_fp32;
        out_id_d    = cap_id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; reset drops any captured or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cap_data_q  <= '0;
      cap_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_fp32_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cap_data_q  <= cap_data_d;
      cap_id_q    <= cap_id_d;
      out_valid_q <= out_valid_d;
      out_fp32_q  <= out_fp32_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp32  = out_fp32_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_int2fp32_rr_sched.sv
// Directed bench for int2fp32_rr_sched: single conversions with hand-derived
// FP32 words, round-robin order, output back-pressure and reset mid-flight.
module tb_int2fp32_rr_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_fp32;
  logic [IW-1:0]    out_id;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  int2fp32_rr_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp32(out_fp32), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    req_valid = '0; out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // One isolated request from requester id; ends at a negedge in IDLE.
  task automatic do_req(input int id, input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_data[id*DW +: DW] = d;
    @(negedge clk); chk("grant", 32'(req_ready), 32'(1 << id));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); chk("conv_state", {busy, out_valid}, 2'b10);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_fp32", out_fp32, exp);
    chk("out_id", 32'(out_id), id);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk); chk("drained", {busy, out_valid}, 2'b00);
  endtask

  logic [31:0] rr_exp [NR];

  initial begin
    // Reset values while rst is high, with a request pending.
    req_valid = 4'b0001;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fp32", out_fp32, 0);
    chk("rst_id", 32'(out_id), 0);
    do_reset();

    do_req(0, 32'h0000_0001, 32'h3F80_0000);
    do_req(1, 32'h0000_0000, 32'h0000_0000);
    do_req(2, 32'h00FF_FFFF, 32'h4B7F_FFFF);
    do_req(3, 32'hFFFF_FFFF, 32'h4F7F_FFFF);
    do_req(0, 32'h8000_0000, 32'h4F00_0000);
    do_req(1, 32'h0000_0003, 32'h4040_0000);
    do_req(2, 32'h0100_0001, 32'h4B80_0000);

    // All requesters held from reset with out_ready high.
    rr_exp[0] = 32'h3F80_0000; rr_exp[1] = 32'h4000_0000;
    rr_exp[2] = 32'h4040_0000; rr_exp[3] = 32'h4080_0000;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'(i + 1);
    req_valid = 4'hF; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      int g;
      g = (c / 3) % NR;
      @(negedge clk);
      case (c % 3)
        0: chk("rr_grant", 32'(req_ready), 32'(1 << g));
        1: chk("rr_conv", {req_ready, busy, out_valid}, {4'b0000, 2'b10});
        default: begin
          chk("rr_valid", 32'(out_valid), 1);
          chk("rr_id", 32'(out_id), g);
          chk("rr_fp32", out_fp32, rr_exp[g]);
        end
      endcase
    end
    @(posedge clk); #1 req_valid = '0; out_ready = 1'b0;

    // Back-pressure in HOLD: outputs frozen, no grants, pointer parked at 3.
    do_reset();
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'd5;
    @(negedge clk); chk("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1001;
    req_data[0 +: DW] = 32'd7; req_data[3*DW +: DW] = 32'd9;
    @(negedge clk); chk("bp_conv_rdy", 32'(req_ready), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_fp32", out_fp32, 32'h40A0_0000);
      chk("bp_id", 32'(out_id), 2);
      chk("bp_rdy", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk); chk("bp_next_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_fp32", out_fp32, 32'h4110_0000);
    chk("bp_next_id", 32'(out_id), 3);

    // Reset while converting: immediate drop, pointer back to requester 0.
    do_reset();
    req_valid = 4'b0001; req_data[0 +: DW] = 32'd1;
    @(negedge clk); chk("rc_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0011;
    chk("rc_in_conv", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rc_rst_state", {busy, out_valid}, 2'b00);
    chk("rc_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rc_after_grant", 32'(req_ready), 32'b0001);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
